// File: rtl/wbuf_ctrl.sv
//==============================================================================
// Module   : wbuf_ctrl
// Purpose  : Store-buffer controller: merges/allocates word stores into a
//            byte-strobed ring buffer and drains entries in FIFO order to AXI.
//            Optional macro WBUF_FWD_EN adds a combinational load-forward port.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module wbuf_ctrl #(
    parameter int BUF_LEN = 8,
    parameter int PTR_W   = $clog2(BUF_LEN),
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic                      st_valid,
    output logic                      st_ready,
    input  logic [ADDR_W-1:0]         st_addr,
    input  logic [DATA_W/8-1:0]       st_strb,
    input  logic [DATA_W-1:0]         st_data,
    output logic [DATA_W-1:0]         rb_data,
    output logic [PTR_W-1:0]          rb_wptr,
    output logic                      rb_wptr_valid,
    output logic [DATA_W/8-1:0]       rb_wtrb,
    output logic                      rb_valid,
    input  logic [DATA_W*BUF_LEN-1:0] rb_data_pack,
`ifdef WBUF_FWD_EN
    input  logic [ADDR_W-1:0]         ld_addr,
    output logic                      ld_hit,
    output logic [DATA_W-1:0]         ld_data,
    output logic [DATA_W/8-1:0]       ld_strb,
`endif
    output logic                      awvalid,
    input  logic                      awready,
    output logic [ADDR_W-1:0]         awaddr,
    output logic                      wvalid,
    input  logic                      wready,
    output logic [DATA_W-1:0]         wdata,
    output logic [DATA_W/8-1:0]       wstrb,
    input  logic                      bvalid,
    output logic                      bready,
    output logic                      wb_empty
);

    localparam int STRB_W = DATA_W / 8;
    localparam int CNT_W  = PTR_W + 1;

    localparam logic [1:0] D_IDLE = 2'd0;
    localparam logic [1:0] D_SEND = 2'd1;
    localparam logic [1:0] D_RESP = 2'd2;

    logic [BUF_LEN-1:0] r_valid;
    logic [ADDR_W-3:0]  r_addr [BUF_LEN];
    logic [STRB_W-1:0]  r_mask [BUF_LEN];
    logic [PTR_W-1:0]   r_head;
    logic [PTR_W-1:0]   r_tail;
    logic [CNT_W-1:0]   r_count;
    logic [1:0]         r_state;
    logic               r_aw_done;
    logic               r_w_done;

    logic               w_hit;
    logic [PTR_W-1:0]   w_hit_idx;
    logic               w_full;
    logic               w_merge;
    logic               w_alloc;
    logic               w_pop;
    logic               w_aw_done_nxt;
    logic               w_w_done_nxt;
    logic               w_unused;

    function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] p, input int k);
        int s;
        s = int'(p) + k;
        if (s >= BUF_LEN) s = s - BUF_LEN;
        return PTR_W'(s);
    endfunction

    // Scan oldest to youngest so the last match is the youngest; the head is
    // locked once its AXI write has been issued.
    always_comb begin
        w_hit     = 1'b0;
        w_hit_idx = '0;
        for (int k = 0; k < BUF_LEN; k++) begin
            if (r_valid[ptr_add(r_head, k)] &&
                r_addr[ptr_add(r_head, k)] == st_addr[ADDR_W-1:2] &&
                !(k == 0 && r_state != D_IDLE)) begin
                w_hit     = 1'b1;
                w_hit_idx = ptr_add(r_head, k);
            end
        end
    end

    assign w_full        = (r_count == CNT_W'(BUF_LEN));
    assign w_merge       = st_valid & w_hit;
    assign w_alloc       = st_valid & ~w_hit & ~w_full;
    assign w_pop         = (r_state == D_RESP) & bvalid;

    assign st_ready      = w_hit | ~w_full;
    assign rb_valid      = w_merge | w_alloc;
    assign rb_wptr_valid = w_hit;
    assign rb_wptr       = w_hit_idx;
    assign rb_data       = st_data;
    assign rb_wtrb       = st_strb;

    assign awvalid  = (r_state == D_SEND) & ~r_aw_done;
    assign wvalid   = (r_state == D_SEND) & ~r_w_done;
    assign bready   = (r_state == D_RESP);
    assign awaddr   = {r_addr[r_head], 2'b00};
    assign wdata    = rb_data_pack[int'(r_head)*DATA_W +: DATA_W];
    assign wstrb    = r_mask[r_head];
    assign wb_empty = ~(|r_valid) & (r_state == D_IDLE);
    assign w_unused = &{1'b0, st_addr[1:0]};

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_valid <= '0;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            for (int i = 0; i < BUF_LEN; i++) begin
                r_mask[i] <= '0;
            end
        end else begin
            if (w_merge) begin
                r_mask[w_hit_idx] <= r_mask[w_hit_idx] | st_strb;
            end
            if (w_pop) begin
                r_valid[r_head] <= 1'b0;
                r_head          <= ptr_add(r_head, 1);
            end
            // A full buffer blocks allocation, so tail never lands on the popped head.
            if (w_alloc) begin
                r_valid[r_tail] <= 1'b1;
                r_addr[r_tail]  <= st_addr[ADDR_W-1:2];
                r_mask[r_tail]  <= st_strb;
                r_tail          <= ptr_add(r_tail, 1);
            end
            if (w_alloc && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_alloc) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    assign w_aw_done_nxt = r_aw_done | awready;
    assign w_w_done_nxt  = r_w_done | wready;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state   <= D_IDLE;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
        end else begin
            case (r_state)
                D_IDLE: begin
                    if (r_valid[r_head]) begin
                        r_state   <= D_SEND;
                        r_aw_done <= 1'b0;
                        r_w_done  <= 1'b0;
                    end
                end
                D_SEND: begin
                    r_aw_done <= w_aw_done_nxt;
                    r_w_done  <= w_w_done_nxt;
                    if (w_aw_done_nxt && w_w_done_nxt) begin
                        r_state <= D_RESP;
                    end
                end
                D_RESP: begin
                    if (bvalid) begin
                        r_state <= D_IDLE;
                    end
                end
                default: r_state <= D_IDLE;
            endcase
        end
    end

`ifdef WBUF_FWD_EN
    logic w_unused_ld;

    // The in-flight head still holds the data, so it is forwardable.
    always_comb begin
        ld_hit  = 1'b0;
        ld_data = '0;
        ld_strb = '0;
        for (int k = 0; k < BUF_LEN; k++) begin
            if (r_valid[ptr_add(r_head, k)] &&
                r_addr[ptr_add(r_head, k)] == ld_addr[ADDR_W-1:2]) begin
                ld_hit  = 1'b1;
                ld_data = rb_data_pack[int'(ptr_add(r_head, k))*DATA_W +: DATA_W];
                ld_strb = r_mask[ptr_add(r_head, k)];
            end
        end
    end

    assign w_unused_ld = &{1'b0, ld_addr[1:0]};
`else
    // No forwarding path: loads wait for wb_empty.
`endif

endmodule

`default_nettype wire

// File: tb/tb_wbuf_ctrl.sv
//==============================================================================
// Module   : tb_wbuf_ctrl
// Purpose  : Self-checking bench for wbuf_ctrl with a queue-level store-buffer
//            model, a ring-buffer model and directed stimulus.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_wbuf_ctrl;

    localparam int BUF_LEN = 8;
    localparam int PTR_W   = 3;
    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int STRB_W  = 4;

    logic                      clk = 1'b0;
    logic                      resetn;
    logic                      st_valid;
    logic                      st_ready;
    logic [ADDR_W-1:0]         st_addr;
    logic [STRB_W-1:0]         st_strb;
    logic [DATA_W-1:0]         st_data;
    logic [DATA_W-1:0]         rb_data;
    logic [PTR_W-1:0]          rb_wptr;
    logic                      rb_wptr_valid;
    logic [STRB_W-1:0]         rb_wtrb;
    logic                      rb_valid;
    logic [DATA_W*BUF_LEN-1:0] rb_data_pack;
    logic                      awvalid, awready;
    logic [ADDR_W-1:0]         awaddr;
    logic                      wvalid, wready;
    logic [DATA_W-1:0]         wdata;
    logic [STRB_W-1:0]         wstrb;
    logic                      bvalid, bready;
    logic                      wb_empty;
`ifdef WBUF_FWD_EN
    logic [ADDR_W-1:0]         ld_addr = '0;
    logic                      ld_hit;
    logic [DATA_W-1:0]         ld_data;
    logic [STRB_W-1:0]         ld_strb;
`endif

    wbuf_ctrl #(.BUF_LEN(BUF_LEN), .PTR_W(PTR_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .resetn(resetn),
        .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr),
        .st_strb(st_strb), .st_data(st_data),
        .rb_data(rb_data), .rb_wptr(rb_wptr), .rb_wptr_valid(rb_wptr_valid),
        .rb_wtrb(rb_wtrb), .rb_valid(rb_valid), .rb_data_pack(rb_data_pack),
`ifdef WBUF_FWD_EN
        .ld_addr(ld_addr), .ld_hit(ld_hit), .ld_data(ld_data), .ld_strb(ld_strb),
`endif
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
        .bvalid(bvalid), .bready(bready), .wb_empty(wb_empty)
    );

    always #5 clk = ~clk;

    // Ring buffer: allocate at its own pointer, merge bytes at rb_wptr.
    logic [DATA_W-1:0] rb_mem [BUF_LEN];
    int                rb_ptr;

    always @(posedge clk) begin
        if (!resetn) begin
            rb_ptr <= 0;
        end else if (rb_valid) begin
            if (rb_wptr_valid) begin
                for (int b = 0; b < STRB_W; b++)
                    if (rb_wtrb[b]) rb_mem[rb_wptr][8*b +: 8] <= rb_data[8*b +: 8];
            end else begin
                rb_mem[rb_ptr] <= rb_data;
                rb_ptr         <= (rb_ptr + 1) % BUF_LEN;
            end
        end
    end

    always_comb begin
        rb_data_pack = '0;
        for (int i = 0; i < BUF_LEN; i++) rb_data_pack[i*DATA_W +: DATA_W] = rb_mem[i];
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Model: FIFO of pending stores (oldest first) and the drain phase of the oldest.
    typedef struct {
        logic [ADDR_W-3:0] wa;
        logic [STRB_W-1:0] mask;
        logic [DATA_W-1:0] data;
        int                slot;
    } ent_t;

    ent_t              q[$];
    logic [31:0]       done_log[$];
    int                m_tail;
    int                phase;     // 0 waiting, 1 address/data issued, 2 awaiting response
    bit                aw_pend, w_pend;
    bit                known = 1'b0;

    task automatic model_reset();
        q.delete();
        m_tail  = 0;
        phase   = 0;
        aw_pend = 1'b0;
        w_pend  = 1'b0;
    endtask

    always @(negedge clk) begin
        int   h;
        bit   full, exp_ready, exp_rbv, pop;
        ent_t e;
        if (known) begin
            h = -1;
            for (int i = 0; i < q.size(); i++)
                if (q[i].wa == st_addr[31:2] && !(i == 0 && phase != 0)) h = i;
            full      = (q.size() == BUF_LEN);
            exp_ready = (h >= 0) || !full;
            exp_rbv   = st_valid && exp_ready;
            if (st_valid || !full) chk("st_ready", 32'(st_ready), 32'(exp_ready));
            chk("rb_valid", 32'(rb_valid), 32'(exp_rbv));
            if (exp_rbv) begin
                chk("rb_wptr_valid", 32'(rb_wptr_valid), 32'(h >= 0));
                if (h >= 0) chk("rb_wptr", 32'(rb_wptr), 32'(q[h].slot));
            end
            chk("awvalid", 32'(awvalid), 32'(phase == 1 && aw_pend));
            chk("wvalid", 32'(wvalid), 32'(phase == 1 && w_pend));
            chk("bready", 32'(bready), 32'(phase == 2));
            chk("wb_empty", 32'(wb_empty), 32'(q.size() == 0 && phase == 0));
            if (phase == 1) begin
                chk("awaddr", awaddr, {q[0].wa, 2'b00});
                chk("wdata", wdata, q[0].data);
                chk("wstrb", 32'(wstrb), 32'(q[0].mask));
            end

            if (!resetn) begin
                model_reset();
            end else begin
                pop = (phase == 2) && bvalid;
                case (phase)
                    0: if (q.size() > 0) begin phase = 1; aw_pend = 1'b1; w_pend = 1'b1; end
                    1: begin
                        if (awready) aw_pend = 1'b0;
                        if (wready)  w_pend  = 1'b0;
                        if (!aw_pend && !w_pend) phase = 2;
                    end
                    default: if (bvalid) phase = 0;
                endcase
                if (st_valid && h >= 0) begin
                    e = q[h];
                    e.mask = e.mask | st_strb;
                    for (int b = 0; b < STRB_W; b++)
                        if (st_strb[b]) e.data[8*b +: 8] = st_data[8*b +: 8];
                    q[h] = e;
                end
                if (pop) begin
                    done_log.push_back({q[0].wa, 2'b00});
                    void'(q.pop_front());
                end
                if (st_valid && h < 0 && !full) begin
                    e.wa = st_addr[31:2]; e.mask = st_strb; e.data = st_data; e.slot = m_tail;
                    q.push_back(e);
                    m_tail = (m_tail + 1) % BUF_LEN;
                end
            end
        end else if (!resetn) begin
            model_reset();
            known = 1'b1;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic store_chk(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d,
                             input bit exp_ready, input bit exp_wpv, input int exp_wptr,
                             input string name);
        st_valid = 1'b1; st_addr = a; st_strb = s; st_data = d;
        #1;
        chk({name, ".st_ready"}, 32'(st_ready), 32'(exp_ready));
        chk({name, ".rb_valid"}, 32'(rb_valid), 32'(exp_ready));
        if (exp_ready) chk({name, ".rb_wptr_valid"}, 32'(rb_wptr_valid), 32'(exp_wpv));
        if (exp_ready && exp_wpv) chk({name, ".rb_wptr"}, 32'(rb_wptr), 32'(exp_wptr));
        cyc();
        st_valid = 1'b0;
    endtask

    task automatic wait_high(input int which, input string name);
        int  n;
        logic v;
        n = 0;
        v = (which == 0) ? awvalid : bready;
        while (v !== 1'b1 && n < 30) begin
            cyc();
            n++;
            v = (which == 0) ? awvalid : bready;
        end
        if (n == 30) chk({name, ".timeout"}, 32'(v), 32'd1);
    endtask

    task automatic drain_one(input logic [31:0] exp_addr, input string name);
        wait_high(0, name);
        chk({name, ".awaddr"}, awaddr, exp_addr);
        awready = 1'b1; wready = 1'b1;
        cyc();
        awready = 1'b0; wready = 1'b0;
        wait_high(1, name);
        bvalid = 1'b1;
        cyc();
        bvalid = 1'b0;
    endtask

    int base;

    initial begin
        resetn = 1'b0; st_valid = 1'b0; st_addr = '0; st_strb = '0; st_data = '0;
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
        chk("rst.st_ready", 32'(st_ready), 32'd1);
        chk("rst.rb_valid", 32'(rb_valid), 32'd0);
        chk("rst.awvalid", 32'(awvalid), 32'd0);
        chk("rst.wvalid", 32'(wvalid), 32'd0);
        chk("rst.bready", 32'(bready), 32'd0);
        chk("rst.wb_empty", 32'(wb_empty), 32'd1);

        // Single store, AXI stalled, then drained.
        store_chk(32'h100, 4'hF, 32'hAABBCCDD, 1, 0, 0, "t1");
        chk("t1.wb_empty", 32'(wb_empty), 32'd0);
        chk("t1.awvalid_idle", 32'(awvalid), 32'd0);
        cyc();
        chk("t1.awvalid", 32'(awvalid), 32'd1);
        chk("t1.wvalid", 32'(wvalid), 32'd1);
        chk("t1.awaddr", awaddr, 32'h100);
        chk("t1.wdata", wdata, 32'hAABBCCDD);
        chk("t1.wstrb", 32'(wstrb), 32'hF);
        drain_one(32'h100, "t1");
        chk("t1.empty_after", 32'(wb_empty), 32'd1);

        // Merge into a head that has not started draining (slot 1).
        store_chk(32'h200, 4'h1, 32'h11111111, 1, 0, 0, "t2a");
        store_chk(32'h202, 4'h4, 32'h22222222, 1, 1, 1, "t2b");
        chk("t2.wstrb", 32'(wstrb), 32'h5);
        chk("t2.wdata", wdata, 32'h11221111);
        drain_one(32'h200, "t2");

        // Fill all entries (slots 2..7,0,1), full reject, merge while full.
        for (int i = 0; i < BUF_LEN; i++)
            store_chk(32'h1000 + 32'(4*i), 4'hF, 32'hD0000000 + 32'(i), 1, 0, 0, "t3fill");
        store_chk(32'h2000, 4'hF, 32'h0, 0, 0, 0, "t3full");
        store_chk(32'h1008, 4'h2, 32'h0000EE00, 1, 1, 4, "t3merge");
        store_chk(32'h1000, 4'hF, 32'h0, 0, 0, 0, "t3headlock");
        base = done_log.size();
        for (int i = 0; i < BUF_LEN; i++) drain_one(32'h1000 + 32'(4*i), "t3drain");
        chk("t3.writes", 32'(done_log.size() - base), 32'd8);
        chk("t3.order5", done_log[base+5], 32'h1014);
        chk("t3.wb_empty", 32'(wb_empty), 32'd1);

        // Staggered handshakes: aw at n, w at n+2, b at n+4.
        store_chk(32'h300, 4'hF, 32'h33333333, 1, 0, 0, "t4");
        wait_high(0, "t4");
        awready = 1'b1;
        cyc();
        awready = 1'b0;
        chk("t4.awvalid_n1", 32'(awvalid), 32'd0);
        chk("t4.wvalid_n1", 32'(wvalid), 32'd1);
        cyc();
        wready = 1'b1;
        cyc();
        wready = 1'b0;
        chk("t4.bready_n3", 32'(bready), 32'd1);
        chk("t4.wvalid_n3", 32'(wvalid), 32'd0);
        cyc();
        bvalid = 1'b1;
        cyc();
        bvalid = 1'b0;
        chk("t4.bready_n5", 32'(bready), 32'd0);
        chk("t4.wb_empty", 32'(wb_empty), 32'd1);

        // Store to the in-flight head address allocates a second entry.
        base = done_log.size();
        store_chk(32'h400, 4'hF, 32'h44444444, 1, 0, 0, "t5a");
        wait_high(0, "t5");
        awready = 1'b1; wready = 1'b1;
        cyc();
        awready = 1'b0; wready = 1'b0;
        chk("t5.bready", 32'(bready), 32'd1);
        store_chk(32'h400, 4'hF, 32'h55555555, 1, 0, 0, "t5b");
        bvalid = 1'b1;
        cyc();
        bvalid = 1'b0;
        wait_high(0, "t5c");
        chk("t5.wdata2", wdata, 32'h55555555);
        drain_one(32'h400, "t5c");
        chk("t5.writes", 32'(done_log.size() - base), 32'd2);

        // Reset in the response phase.
        store_chk(32'h500, 4'hF, 32'h66666666, 1, 0, 0, "t6");
        wait_high(0, "t6");
        awready = 1'b1; wready = 1'b1;
        cyc();
        awready = 1'b0; wready = 1'b0;
        chk("t6.bready_pre", 32'(bready), 32'd1);
        resetn = 1'b0;
        cyc();
        resetn = 1'b1;
        chk("t6.awvalid", 32'(awvalid), 32'd0);
        chk("t6.wvalid", 32'(wvalid), 32'd0);
        chk("t6.bready", 32'(bready), 32'd0);
        chk("t6.wb_empty", 32'(wb_empty), 32'd1);
        chk("t6.st_ready", 32'(st_ready), 32'd1);
        store_chk(32'h600, 4'h3, 32'h77777777, 1, 0, 0, "t6post");
        drain_one(32'h600, "t6post");
        chk("t6.wb_empty_end", 32'(wb_empty), 32'd1);

        cyc();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/wbuf_ctrl.md
Name: wbuf_ctrl

Overview:
- Controller and scheduler for the byte-strobed ring buffer used as the CPU store/write buffer.
- Accepts word stores from the memory stage and allocates or merges them into ring-buffer entries.
- Tracks per-entry address, valid and accumulated byte mask.
- Drains the oldest entry in FIFO order to the AXI write channel; reports empty for SYNC/uncached ordering.

Parameters:
- BUF_LEN, 8, number of entries; must match the ring buffer's buf_length.
- PTR_W, $clog2(BUF_LEN), entry pointer width.
- ADDR_W, 32, byte address width.
- DATA_W, 32, data word width; strobe width is DATA_W/8.

Ports:
- clk  in  1  clock
- resetn  in  1  synchronous active-low reset
- st_valid  in  1  store request
- st_ready  out  1  store accepted this cycle when st_valid is also high
- st_addr  in  ADDR_W  store byte address; low 2 bits ignored
- st_strb  in  DATA_W/8  byte enables
- st_data  in  DATA_W  store data
- rb_data  out  DATA_W  ring-buffer write data (= st_data)
- rb_wptr  out  PTR_W  merge target entry
- rb_wptr_valid  out  1  1 = merge into rb_wptr; 0 = allocate at the ring buffer's internal pointer
- rb_wtrb  out  DATA_W/8  merge strobes (= st_strb)
- rb_valid  out  1  ring-buffer write enable
- rb_data_pack  in  DATA_W*BUF_LEN  all entry contents
- awvalid/awready  out/in  1  AXI write address handshake
- awaddr  out  ADDR_W  word-aligned head address
- wvalid/wready  out/in  1  AXI write data handshake
- wdata  out  DATA_W  head entry data
- wstrb  out  DATA_W/8  head accumulated mask
- bvalid/bready  in/out  1  AXI write response handshake
- wb_empty  out  1  no valid entries and drain FSM in D_IDLE

Behaviour:
- Reset: all valid bits, masks, head, tail and count = 0; FSM = D_IDLE; st_ready=1, rb_valid=0, awvalid=0, wvalid=0, bready=0, wb_empty=1.
- Clock and reset: all state updates on the posedge of clk; resetn is synchronous and active-low. The ring buffer shares the same reset, so tail stays aligned with its internal pointer.
- Hit search (combinational):
  - An entry hits if it is valid, its addr[ADDR_W-1:2] equals st_addr[ADDR_W-1:2], and it is not the head while the FSM is in D_SEND or D_RESP.
  - Match the youngest hit; at most one hit can exist by construction.
- Merge: on st_valid and hit, st_ready=1.
  - Drive rb_valid=1, rb_wptr_valid=1, rb_wptr = hit index.
  - mask[hit] |= st_strb. Count is unchanged.
- Allocate: on st_valid, no hit and count<BUF_LEN, st_ready=1.
  - Drive rb_valid=1, rb_wptr_valid=0.
  - Entry[tail]: addr = st_addr, mask = st_strb, valid = 1.
  - Tail wraps BUF_LEN-1 to 0; count +1.
- Full: on st_valid, no hit and count==BUF_LEN, st_ready=0 and rb_valid=0. A merge into a full buffer is still accepted.
- Drain FSM:
  - D_IDLE: if the head entry is valid, go to D_SEND and assert awvalid and wvalid together.
  - D_SEND: awvalid and wvalid drop independently on their own handshakes. Go to D_RESP once both have completed, including completion in the same cycle.
  - D_RESP: bready=1. On bvalid, clear valid[head], advance head with wrap, count -1, return to D_IDLE. Minimum occupancy is 3 cycles per entry.
  - awaddr, wdata and wstrb come from head and remain stable from D_SEND entry until the handshakes complete.
- Simultaneous allocate and pop in one cycle: count is unchanged, and both head and tail move.
- Allocating into the slot freed in the same cycle is not allowed. Full is evaluated on the registered count.
- bresp is ignored.

Optional Feature:
- WBUF_FWD_EN defined: adds inputs ld_addr (ADDR_W) and outputs ld_hit (1), ld_data (DATA_W), ld_strb (DATA_W/8), all combinational.
  - ld_hit=1 if any valid entry matches the word address, including the head in flight.
  - ld_data = that entry from rb_data_pack; ld_strb = its mask.
- WBUF_FWD_EN undefined: these ports are absent. Loads must wait for wb_empty.

Test Plan:
- Store 0x100 strb 4'hF data 0xAABBCCDD, awready and wready held 0 -> rb_valid=1, rb_wptr_valid=0; count 1; after 1 cycle awvalid=1, awaddr=0x100, wdata=0xAABBCCDD, wstrb=4'hF.
- With 0x200 allocated as strb 4'h1 and not yet draining, store 0x202 strb 4'h4 -> rb_wptr_valid=1, rb_wptr=that entry, count unchanged; drained wstrb=4'h5.
- Fill 8 distinct addresses with AXI stalled, then a 9th new address -> st_ready=0. A store to an existing non-head address -> st_ready=1 (merge). Release AXI -> 8 writes in allocation order, wb_empty=1 afterwards.
- awready in cycle n, wready in cycle n+2, bvalid in cycle n+4 -> single pop, head+1, FSM back to D_IDLE.
- Store to the head address during D_RESP -> allocates a new entry, not a merge; 2 AXI writes issued.
- Reset asserted mid-D_RESP -> next cycle awvalid=0, wvalid=0, bready=0, wb_empty=1, st_ready=1.
